// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with a small byte FIFO and runtime bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
`timescale 1ns/1ps
module uart_tx_core #(
  parameter int DEPTH     = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIV_WIDTH-1:0]   cfg_div_i,
  input  logic                   tx_valid_i,
  input  logic [7:0]             tx_data_i,
  output logic                   tx_ready_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [7:0]           mem_q [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        lvl_q;
  logic [7:0]           sh_q, sh_d;
  logic [2:0]           bit_q, bit_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic push, pop, bit_end, full;
  logic [7:0] head;

  assign full       = (lvl_q == LW'(DEPTH));
  assign tx_ready_o = ~full;
  assign push       = tx_valid_i & ~full;
  assign head       = mem_q[rd_q];
  assign bit_end    = (cnt_q == div_q);

  assign tx_o         = tx_q;
  assign fifo_level_o = lvl_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE)
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE:
        if (lvl_q != '0) pop = 1'b1;
      START:
        if (bit_end) state_d = DATA;
      DATA:
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
          sh_d  = sh_q >> 1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (bit_end) state_d = STOP;
`endif
      STOP:
        if (bit_end) begin
          if (lvl_q != '0) pop = 1'b1;
          else state_d = IDLE;
        end
      default:
        state_d = IDLE;
    endcase
    // A pop always begins a fresh frame with a freshly latched period.
    if (pop) begin
      state_d = START;
      sh_d    = head;
      bit_d   = '0;
      cnt_d   = '0;
      div_d   = cfg_div_i;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_o = (state_q != IDLE) | (lvl_q != '0);
  end

endmodule
